// File: rtl/cpu_clock_ctrl_if.sv
// Request/status bundle between the front panel, the clock divider, the CPU and cpu_clock_ctrl.
interface cpu_clock_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic             clock_div;
    logic             run_req;
    logic             halt_req;
    logic             step_req;
    logic             cpu_halt;
    logic             cpu_en;
    logic [1:0]       mode;
    logic [CNT_W-1:0] cycle_count;
    logic             halted_by_cpu;

    modport master (
        output clock_div, run_req, halt_req, step_req, cpu_halt,
        input  cpu_en, mode, cycle_count, halted_by_cpu
    );

    modport slave (
        input  clock_div, run_req, halt_req, step_req, cpu_halt,
        output cpu_en, mode, cycle_count, halted_by_cpu
    );
endinterface

// File: rtl/cpu_clock_ctrl.sv
// Turns divided-clock rising edges into gated single-cycle CPU enables (run/halt/step) and counts them.
// Optional request debounce filter enabled with `define BTN_DEBOUNCE_EN.
module cpu_clock_ctrl #(
    parameter int unsigned CNT_W = 32
`ifdef BTN_DEBOUNCE_EN
    , parameter int unsigned DEBOUNCE_CYCLES = 16
`endif
) (
    input  logic            clk,
    input  logic            reset,
    cpu_clock_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        HALTED    = 2'd0,
        RUNNING   = 2'd1,
        STEP_WAIT = 2'd2
    } mode_e;

    mode_e            state;
    logic             cpu_en;
    logic [CNT_W-1:0] cycle_count;
    logic             halted_by_cpu;

    // Request vectors are ordered {step, halt, run}.
    logic [2:0] req_raw;
    logic [2:0] req_lvl;
    logic [2:0] req_q;
    logic [2:0] req_e;
    logic       clock_div_q;
    logic       tick;
    logic       run_e;
    logic       halt_e;
    logic       step_e;
    logic       issue;

    assign req_raw = {bus.step_req, bus.halt_req, bus.run_req};

`ifdef BTN_DEBOUNCE_EN
    localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [DB_W-1:0] db_cnt [3];

    // Filtered level follows the raw input only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_lvl <= '1;
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (req_raw[i] == req_lvl[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    req_lvl[i] <= req_raw[i];
                    db_cnt[i]  <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end
`else
    assign req_lvl = req_raw;
`endif

    assign tick   = bus.clock_div & ~clock_div_q;
    assign req_e  = req_lvl & ~req_q;
    assign run_e  = req_e[0];
    assign halt_e = req_e[1];
    assign step_e = req_e[2];

    // A tick becomes a pulse only when no halt source wins in the same cycle.
    assign issue = tick & ~halt_e &
                   (((state == RUNNING) & ~bus.cpu_halt) | (state == STEP_WAIT));

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= HALTED;
            clock_div_q   <= 1'b1;
            req_q         <= '1;
            cpu_en        <= 1'b0;
            cycle_count   <= '0;
            halted_by_cpu <= 1'b0;
        end else begin
            clock_div_q <= bus.clock_div;
            req_q       <= req_lvl;
            cpu_en      <= issue;
            if (issue && (cycle_count != '1)) begin
                cycle_count <= cycle_count + CNT_W'(1);
            end

            unique case (state)
                HALTED: begin
                    if (!halt_e) begin
                        if (run_e) begin
                            state         <= RUNNING;
                            halted_by_cpu <= 1'b0;
                        end else if (step_e) begin
                            state         <= STEP_WAIT;
                            halted_by_cpu <= 1'b0;
                        end
                    end
                end
                RUNNING: begin
                    if (bus.cpu_halt) begin
                        state         <= HALTED;
                        halted_by_cpu <= 1'b1;
                    end else if (halt_e) begin
                        state         <= HALTED;
                        halted_by_cpu <= 1'b0;
                    end
                end
                STEP_WAIT: begin
                    if (halt_e || tick) begin
                        state         <= HALTED;
                        halted_by_cpu <= 1'b0;
                    end
                end
                default: state <= HALTED;
            endcase
        end
    end

    assign bus.cpu_en        = cpu_en;
    assign bus.mode          = 2'(state);
    assign bus.cycle_count   = cycle_count;
    assign bus.halted_by_cpu = halted_by_cpu;

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Scoreboard bench for cpu_clock_ctrl: directed scenarios plus random stimulus against a cycle-level model.
module tb_cpu_clock_ctrl;

`ifdef BTN_DEBOUNCE_EN
    localparam int REQ_W = 20;
`else
    localparam int REQ_W = 2;
`endif
    localparam int DEBOUNCE = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cpu_clock_ctrl_if #(.CNT_W(32)) bus32 ();
    cpu_clock_ctrl_if #(.CNT_W(4))  bus4 ();

    assign bus4.clock_div = bus32.clock_div;
    assign bus4.run_req   = bus32.run_req;
    assign bus4.halt_req  = bus32.halt_req;
    assign bus4.step_req  = bus32.step_req;
    assign bus4.cpu_halt  = bus32.cpu_halt;

    cpu_clock_ctrl #(.CNT_W(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32));
    cpu_clock_ctrl #(.CNT_W(4))  dut4  (.clk(clk), .reset(reset), .bus(bus4));

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model + monitor ----------------
    int     cyc = 0;
    int     m_mode = 0;
    bit     m_hbc = 1'b0;
    longint m_n = 0;
    bit     prev_cd = 1'b1;
    bit [2:0] prev_lvl = '1;
    int     exp_q[$];
`ifdef BTN_DEBOUNCE_EN
    bit [2:0] f_lvl = '1;
    int       stable [3] = '{0, 0, 0};
`endif

    task automatic model_step();
        bit [2:0] raw;
        bit [2:0] lvl;
        bit [2:0] e;
        bit       tick;
        bit       fire;
        cyc++;
        raw = {bus32.step_req, bus32.halt_req, bus32.run_req};
        if (reset) begin
            m_mode = 0; m_hbc = 1'b0; m_n = 0;
            prev_cd = 1'b1; prev_lvl = '1;
`ifdef BTN_DEBOUNCE_EN
            f_lvl = '1;
            for (int i = 0; i < 3; i++) stable[i] = 0;
`endif
            exp_q.delete();
            return;
        end
`ifdef BTN_DEBOUNCE_EN
        lvl = f_lvl;
`else
        lvl = raw;
`endif
        tick = bus32.clock_div && !prev_cd;
        e = lvl & ~prev_lvl;
        prev_cd = bus32.clock_div;
        prev_lvl = lvl;
`ifdef BTN_DEBOUNCE_EN
        for (int i = 0; i < 3; i++) begin
            if (raw[i] == f_lvl[i]) stable[i] = 0;
            else begin
                stable[i]++;
                if (stable[i] == DEBOUNCE) begin f_lvl[i] = raw[i]; stable[i] = 0; end
            end
        end
`endif
        fire = 1'b0;
        case (m_mode)
            0: if (!e[1]) begin
                   if (e[0]) begin m_mode = 1; m_hbc = 1'b0; end
                   else if (e[2]) begin m_mode = 2; m_hbc = 1'b0; end
               end
            1: if (bus32.cpu_halt) begin m_mode = 0; m_hbc = 1'b1; end
               else if (e[1]) begin m_mode = 0; m_hbc = 1'b0; end
               else if (tick) fire = 1'b1;
            default: if (e[1]) m_mode = 0;
                     else if (tick) begin fire = 1'b1; m_mode = 0; end
        endcase
        if (fire) begin
            m_n++;
            exp_q.push_back(cyc);
        end
    endtask

    task automatic monitor_step();
        logic [63:0] e32;
        logic [63:0] e4;
        e32 = (m_n > 64'(32'hFFFF_FFFF)) ? 64'(32'hFFFF_FFFF) : 64'(m_n);
        e4  = (m_n > 15) ? 64'd15 : 64'(m_n);
        check("mode32",  64'(bus32.mode), 64'(m_mode));
        check("mode4",   64'(bus4.mode),  64'(m_mode));
        check("hbc32",   64'(bus32.halted_by_cpu), 64'(m_hbc));
        check("hbc4",    64'(bus4.halted_by_cpu),  64'(m_hbc));
        check("count32", 64'(bus32.cycle_count), e32);
        check("count4",  64'(bus4.cycle_count),  e4);
        if (exp_q.size() > 0 && exp_q[0] == cyc) begin
            void'(exp_q.pop_front());
            check("pulse32", 64'(bus32.cpu_en), 64'd1);
            check("pulse4",  64'(bus4.cpu_en),  64'd1);
        end else begin
            check("nopulse32", 64'(bus32.cpu_en), 64'd0);
            check("nopulse4",  64'(bus4.cpu_en),  64'd0);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #2;
            monitor_step();
        end
    end

    // ---------------- stimulus ----------------
    bit cd_run = 1'b0;
    int cd_ph  = 0;
    int seen   = 0;

    task automatic tick_n(input int n);
        repeat (n) begin
            @(negedge clk);
            if (bus32.cpu_en === 1'b1) seen++;
            if (cd_run) begin
                cd_ph = (cd_ph + 1) % 8;
                bus32.clock_div = (cd_ph < 4);
            end
        end
    endtask

    task automatic wait_cd_rise();
        int t = 0;
        do begin tick_n(1); t++; end while (cd_ph != 0 && t < 20);
        check("cd_rise_found", 64'(cd_ph), 64'd0);
    endtask

    task automatic wait_pulse(input int k);
        int s0 = seen;
        int t  = 0;
        while ((seen - s0) < k && t < 400) begin tick_n(1); t++; end
        check("wait_pulse", 64'(seen - s0), 64'(k));
    endtask

    task automatic pulse_req(input int which);
        case (which)
            0: bus32.run_req = 1'b1;
            1: bus32.halt_req = 1'b1;
            default: bus32.step_req = 1'b1;
        endcase
        tick_n(REQ_W);
        bus32.run_req = 1'b0; bus32.halt_req = 1'b0; bus32.step_req = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int s0;
        bus32.clock_div = 1'b0; bus32.run_req = 1'b0; bus32.halt_req = 1'b0;
        bus32.step_req = 1'b0;  bus32.cpu_halt = 1'b0;
        reset = 1'b1;
        tick_n(3);
        reset = 1'b0;

        // 1: free-running divided clock, no requests
        cd_run = 1'b1;
        s0 = seen;
        tick_n(100);
        check("t1_pulses", 64'(seen - s0), 64'd0);
        check("t1_count", 64'(bus32.cycle_count), 64'd0);

        // 2: run for five ticks then halt
        s0 = seen;
        pulse_req(0);
        wait_pulse(5 - (seen - s0));
        pulse_req(1);
        tick_n(40);
        check("t2_mode", 64'(bus32.mode), 64'd0);
`ifndef BTN_DEBOUNCE_EN
        check("t2_pulses", 64'(seen - s0), 64'd5);
        check("t2_count", 64'(bus32.cycle_count), 64'd5);
`endif

        // 3: three single steps, one extra step request while waiting
        s0 = seen;
        for (int i = 0; i < 3; i++) begin
            wait_cd_rise();
            bus32.step_req = 1'b1; tick_n(2); bus32.step_req = 1'b0;
            if (i == 0) begin
                tick_n(1);
`ifndef BTN_DEBOUNCE_EN
                check("t3_step_wait", 64'(bus32.mode), 64'd2);
`endif
                bus32.step_req = 1'b1; tick_n(1); bus32.step_req = 1'b0;
            end
            tick_n(REQ_W + 20);
        end
        check("t3_mode", 64'(bus32.mode), 64'd0);
`ifndef BTN_DEBOUNCE_EN
        check("t3_pulses", 64'(seen - s0), 64'd3);
        check("t3_count", 64'(bus32.cycle_count), 64'd8);
`endif

        // 4: cpu_halt coinciding with a tick, then restart
        pulse_req(0);
        wait_pulse(2);
        wait_cd_rise();
        bus32.cpu_halt = 1'b1;
        s0 = seen;
        tick_n(3);
        check("t4_suppressed", 64'(seen - s0), 64'd0);
        check("t4_mode", 64'(bus32.mode), 64'd0);
        check("t4_hbc", 64'(bus32.halted_by_cpu), 64'd1);
        bus32.cpu_halt = 1'b0;
        pulse_req(0);
        check("t4_hbc_clear", 64'(bus32.halted_by_cpu), 64'd0);
        check("t4_running", 64'(bus32.mode), 64'd1);
        pulse_req(1);
        tick_n(2);
        bus32.cpu_halt = 1'b1;
        pulse_req(0);
        tick_n(2);
        check("t4_run_into_halt", 64'(bus32.mode), 64'd0);
        check("t4_run_into_halt_hbc", 64'(bus32.halted_by_cpu), 64'd1);
        bus32.cpu_halt = 1'b0;

        // 5: simultaneous run+halt, then reset with a step pending
        bus32.run_req = 1'b1; bus32.halt_req = 1'b1;
        tick_n(REQ_W);
        bus32.run_req = 1'b0; bus32.halt_req = 1'b0;
        tick_n(3);
        check("t5_stay_halted", 64'(bus32.mode), 64'd0);
        wait_cd_rise();
        bus32.step_req = 1'b1;
        s0 = seen;
        tick_n(3);
        reset = 1'b1;
        tick_n(2);
        reset = 1'b0;
        bus32.step_req = 1'b0;
        tick_n(20);
        check("t5_no_pulse", 64'(seen - s0), 64'd0);
        check("t5_mode", 64'(bus32.mode), 64'd0);
        check("t5_count", 64'(bus32.cycle_count), 64'd0);
        check("t5_hbc", 64'(bus32.halted_by_cpu), 64'd0);

        // 6: saturation of the narrow counter
        pulse_req(0);
        wait_pulse(20);
        check("t6_count4_sat", 64'(bus4.cycle_count), 64'd15);
        check("t6_count32", 64'(bus32.cycle_count), 64'd20);
        pulse_req(1);
        tick_n(4);

`ifdef BTN_DEBOUNCE_EN
        // debounce: short glitch ignored, full hold accepted after DEBOUNCE+1 cycles
        cd_run = 1'b0;
        bus32.run_req = 1'b1; tick_n(5); bus32.run_req = 1'b0;
        tick_n(30);
        check("db_glitch", 64'(bus32.mode), 64'd0);
        bus32.run_req = 1'b1;
        tick_n(DEBOUNCE);
        check("db_not_yet", 64'(bus32.mode), 64'd0);
        tick_n(1);
        check("db_enter_run", 64'(bus32.mode), 64'd1);
        bus32.run_req = 1'b0;
        pulse_req(1);
        tick_n(4);
        cd_run = 1'b1;
`endif

        // random phase
        for (int i = 0; i < 3000; i++) begin
            tick_n(1);
            if (i % 500 == 0) cd_run = ($urandom_range(0, 2) != 0);
            if (!cd_run && $urandom_range(0, 3) == 0) bus32.clock_div = ~bus32.clock_div;
            if ($urandom_range(0, 29) == 0) bus32.run_req  = ~bus32.run_req;
            if ($urandom_range(0, 39) == 0) bus32.halt_req = ~bus32.halt_req;
            if ($urandom_range(0, 29) == 0) bus32.step_req = ~bus32.step_req;
            if (bus32.cpu_halt) begin
                if ($urandom_range(0, 2) == 0) bus32.cpu_halt = 1'b0;
            end else if ($urandom_range(0, 79) == 0) bus32.cpu_halt = 1'b1;
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 699) == 0) reset = 1'b1;
        end

        reset = 1'b0;
        cd_run = 1'b0;
        tick_n(5);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
